// File: rtl/serial_frame_rx_if.sv
// Serial receiver bus: line/enable from upstream, word and status pulses back.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              si;
  logic              en;
  logic [DATA_W-1:0] po;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [7:0]        frame_cnt;

  modport master (
    output si, en,
    input  po, valid, parity_err, frame_err, busy, frame_cnt
  );

  modport slave (
    input  si, en,
    output po, valid, parity_err, frame_err, busy, frame_cnt
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Frame receiver: start bit, LSB-first data, optional even parity, stop bit.
// One bit per enabled clock; status outputs are single-cycle registered pulses.
//
// state     | meaning
// IDLE      | line idle, waiting for a 0 start bit
// DATA      | shifting in DATA_W data bits
// PARITY    | sampling the even-parity bit
// STOP      | sampling the stop bit, issuing result pulse
// WAIT_IDLE | framing error, waiting for the line to return to 1
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  serial_frame_rx_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bad_q, par_bad_d;
  logic [DATA_W-1:0] po_q, po_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      po_q        <= '0;
      frame_cnt_q <= 8'd0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      po_q        <= po_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_bad_d   = par_bad_q;
    po_d        = po_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;

    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (!bus.si) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_bad_d = 1'b0;
          end
        end
        DATA: begin
          // LSB arrives first and ends up in bit 0 after DATA_W shifts
          shift_d   = {bus.si, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_bad_d = bus.si ^ (^shift_q);
          state_d   = STOP;
        end
        STOP: begin
          if (bus.si) begin
            state_d = IDLE;
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              po_d        = shift_q;
              valid_d     = 1'b1;
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end else begin
            state_d = WAIT_IDLE;
            ferr_d  = 1'b1;
            perr_d  = par_bad_q;
          end
        end
        WAIT_IDLE: begin
          if (bus.si) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.po         = po_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
